vr_rr_arbiter: RTL and testbench

Parametrised N-channel valid/ready merge stage: arbitrates several valid/ready sources onto one valid/ready sink using round-robin with a configurable burst hold. It is the multi-channel successor of the single source→sink link: each source connects as a master, and the output drives one slave. Accepted beats are registered once, tagged with their source channel, and counted per channel.

---
 rtl/vr_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_vr_rr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vr_rr_arbiter
//  Purpose  : N-channel valid/ready merge with round-robin arbitration, burst
//             hold, a registered output stage and per-channel beat counters.
//  Revision : 1.0 - initial release
// ============================================================================

module vr_rr_arbiter #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   in_data,
    output logic [CHANNELS-1:0]              in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(CHANNELS)-1:0]      out_chan,
    input  logic                             out_ready,
    output logic [CHANNELS*CNT_WIDTH-1:0]    beat_cnt
);

    localparam int CW        = $clog2(CHANNELS);
    localparam int c_burst_w = $clog2(BURST + 1);

    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [CW-1:0]          r_out_chan;
    logic [CW-1:0]          r_owner;
    logic [CW-1:0]          r_ptr;
    logic [c_burst_w-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_beat_cnt [CHANNELS];

    logic                   w_load_en;
    logic                   w_hold;
    logic                   w_found;
    logic                   w_accept;
    logic [CHANNELS-1:0]    w_rot;
    logic [CW:0]            w_sum;
    logic [CW-1:0]          w_search;
    logic [CW-1:0]          w_grant;
    logic [CW-1:0]          w_next_ptr;
    logic [c_burst_w-1:0]   w_next_cnt;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    always_comb begin
        w_load_en = !r_out_valid || out_ready;
        w_hold    = (r_cnt != '0) && in_valid[r_owner];

        // Rotate the request vector so bit 0 is the channel at the search pointer.
        w_rot   = CHANNELS'({in_valid, in_valid} >> r_ptr);
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (CW+1)'(k);
            end
        end
        w_search = (w_sum >= (CW+1)'(CHANNELS)) ? CW'(w_sum - (CW+1)'(CHANNELS))
                                                : w_sum[CW-1:0];

        w_grant  = w_hold ? r_owner : w_search;
        // The granted channel is always valid, so a grant is an accept.
        w_accept = reset && w_load_en && (w_hold || w_found);

        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = w_accept && (w_grant == CW'(i));
        end

        w_sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == CW'(i)) begin
                w_sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        w_next_cnt = w_hold ? (r_cnt + 1'b1) : c_burst_w'(1);
        w_next_ptr = (w_grant == CW'(CHANNELS - 1)) ? '0 : (w_grant + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_beat_cnt[i] <= '0;
            end
        end else if (w_load_en) begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_grant;
                r_ptr       <= w_next_ptr;
                if (w_next_cnt == c_burst_w'(BURST)) begin
                    r_cnt <= '0;
                end else begin
                    r_owner <= w_grant;
                    r_cnt   <= w_next_cnt;
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_grant == CW'(i)) begin
                        r_beat_cnt[i] <= r_beat_cnt[i] + 1'b1;
                    end
                end
            end else begin
                // Output drains; any burst in progress is abandoned.
                r_out_valid <= 1'b0;
                r_cnt       <= '0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_beat_cnt
            assign beat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_beat_cnt[i];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vr_rr_arbiter
//  Purpose  : Directed and scoreboarded checks of vr_rr_arbiter; dut_a runs
//             pure round-robin with 4-bit counters, dut_b a burst of 3.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_vr_rr_arbiter;

    localparam int SEED = 17;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic [3:0]  in_valid  = '0;
    logic [31:0] in_data   = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  in_ready_a,  in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [7:0]  out_data_a,  out_data_b;
    logic [1:0]  out_chan_a,  out_chan_b;
    logic [15:0] beat_cnt_a;
    logic [63:0] beat_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vr_rr_arbiter #(.CHANNELS(4), .DATA_WIDTH(8), .BURST(1), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_chan(out_chan_a), .out_ready(out_ready), .beat_cnt(beat_cnt_a)
    );

    vr_rr_arbiter #(.CHANNELS(4), .DATA_WIDTH(8), .BURST(3), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_chan(out_chan_b), .out_ready(out_ready), .beat_cnt(beat_cnt_b)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = '0; out_ready = 1'b1;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h44332211;
        step(); step();
        n_checks++; if (in_ready_a !== 4'h0) begin n_fail++; $display("FAIL reset_in_ready_a: got %h expected 0", in_ready_a); end
        n_checks++; if (in_ready_b !== 4'h0) begin n_fail++; $display("FAIL reset_in_ready_b: got %h expected 0", in_ready_b); end
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a); end
        n_checks++; if (out_data_a !== 8'h00 || out_chan_a !== 2'd0) begin n_fail++; $display("FAIL reset_out_regs: got data %h chan %0d expected 0/0", out_data_a, out_chan_a); end
        n_checks++; if (beat_cnt_a !== 16'h0 || beat_cnt_b !== 64'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h expected 0", beat_cnt_a, beat_cnt_b); end
        reset = 1'b1;
        #1;
        n_checks++; if (in_ready_a !== 4'b0001) begin n_fail++; $display("FAIL release_in_ready: got %b expected 0001", in_ready_a); end
        step();
        n_checks++; if (out_valid_a !== 1'b1 || out_chan_a !== 2'd0 || out_data_a !== 8'h11) begin
            n_fail++; $display("FAIL first_beat: got v=%b chan=%0d data=%h expected 1/0/11", out_valid_a, out_chan_a, out_data_a);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] tag [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        in_valid = 4'hF; in_data = 32'h44332211;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++; if (out_chan_a !== 2'(k % 4) || out_data_a !== tag[k % 4]) begin
                n_fail++; $display("FAIL rr_beat%0d: got chan=%0d data=%h expected chan=%0d data=%h", k, out_chan_a, out_data_a, k % 4, tag[k % 4]);
            end
        end
        n_checks++; if (beat_cnt_a !== 16'h2222) begin n_fail++; $display("FAIL rr_counts: got %h expected 2222", beat_cnt_a); end
        in_valid = '0;
    endtask

    task automatic test_burst();
        int seq1 [9] = '{1, 1, 1, 2, 2, 2, 1, 1, 1};
        int seq2 [5] = '{2, 2, 1, 1, 1};
        do_reset();
        in_valid = 4'b0110; in_data = 32'h44332211;
        for (int k = 0; k < 9; k++) begin
            step();
            n_checks++; if (out_chan_b !== 2'(seq1[k])) begin n_fail++; $display("FAIL burst_seq%0d: got %0d expected %0d", k, out_chan_b, seq1[k]); end
        end
        // Break channel 1's burst after two beats.
        do_reset();
        in_valid = 4'b0110;
        step(); step();
        in_valid = 4'b0100;
        #1;
        n_checks++; if (in_ready_b !== 4'b0100) begin n_fail++; $display("FAIL broken_burst_ready: got %b expected 0100", in_ready_b); end
        step();
        n_checks++; if (out_chan_b !== 2'd2) begin n_fail++; $display("FAIL broken_burst_grant: got %0d expected 2", out_chan_b); end
        in_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if (out_chan_b !== 2'(seq2[k])) begin n_fail++; $display("FAIL after_break%0d: got %0d expected %0d", k, out_chan_b, seq2[k]); end
        end
        n_checks++; if (beat_cnt_b[16 +: 16] !== 16'd5 || beat_cnt_b[32 +: 16] !== 16'd3) begin
            n_fail++; $display("FAIL burst_counts: got ch1=%0d ch2=%0d expected 5/3", beat_cnt_b[16 +: 16], beat_cnt_b[32 +: 16]);
        end
        in_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        do_reset();
        out_ready = 1'b0; in_valid = 4'b0001; in_data = 32'h000000A5;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== 8'hA5 || in_ready_a !== 4'h0 || beat_cnt_a[3:0] !== 4'd1) begin
                n_fail++; $display("FAIL stall%0d: got v=%b data=%h ready=%b cnt=%0d expected 1/a5/0000/1", k, out_valid_a, out_data_a, in_ready_a, beat_cnt_a[3:0]);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 8'hB0 + 8'(k);
            in_data[7:0] = d;
            step();
            n_checks++; if (out_data_a !== d || beat_cnt_a[3:0] !== 4'(2 + k)) begin
                n_fail++; $display("FAIL resume%0d: got data=%h cnt=%0d expected %h/%0d", k, out_data_a, beat_cnt_a[3:0], d, 2 + k);
            end
        end
        in_valid = '0;
        step();
        n_checks++; if (out_valid_a !== 1'b0 || out_data_a !== 8'hB3 || beat_cnt_a !== 16'h0005) begin
            n_fail++; $display("FAIL drain: got v=%b data=%h cnt=%h expected 0/b3/0005", out_valid_a, out_data_a, beat_cnt_a);
        end
    endtask

    task automatic test_random();
        int exp_seq [4]  = '{default: 0};
        int src_seq [4]  = '{default: 0};
        int idle    [4]  = '{default: 0};
        int wait_cnt[4]  = '{default: 0};
        int acc_cnt [4]  = '{default: 0};
        logic [3:0] acc;
        logic [7:0] exp_d;
        int c;
        do_reset();
        void'($urandom(SEED));
        acc = '0;
        for (int cyc = 0; cyc < 1010; cyc++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (acc[ch]) begin
                    in_valid[ch] = 1'b0;
                    idle[ch] = int'($urandom_range(0, 5));
                end
            end
            if (cyc < 1000) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (!in_valid[ch]) begin
                        if (idle[ch] > 0) idle[ch]--;
                        else begin
                            in_valid[ch] = 1'b1;
                            in_data[ch*8 +: 8] = {2'(ch), 6'(src_seq[ch])};
                        end
                    end
                end
            end
            out_ready = (cyc >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            acc = in_valid & in_ready_a;
            if (out_valid_a && out_ready) begin
                c = int'(out_chan_a);
                exp_d = {out_chan_a, 6'(exp_seq[c])};
                n_checks++; if (out_data_a !== exp_d) begin n_fail++; $display("FAIL order_ch%0d: got %h expected %h", c, out_data_a, exp_d); end
                exp_seq[c]++;
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (acc[ch]) begin
                    src_seq[ch]++;
                    acc_cnt[ch]++;
                    wait_cnt[ch] = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (j != ch && in_valid[j]) begin
                            wait_cnt[j]++;
                            n_checks++; if (wait_cnt[j] > 3) begin n_fail++; $display("FAIL starve_ch%0d: got %0d grants passed expected <= 3", j, wait_cnt[j]); end
                        end
                    end
                end
            end
            step();
        end
        in_valid = '0;
        for (int ch = 0; ch < 4; ch++) begin
            n_checks++; if (exp_seq[ch] !== acc_cnt[ch] || beat_cnt_a[ch*4 +: 4] !== 4'(acc_cnt[ch])) begin
                n_fail++; $display("FAIL totals_ch%0d: got delivered=%0d cnt=%0d expected %0d", ch, exp_seq[ch], beat_cnt_a[ch*4 +: 4], acc_cnt[ch]);
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        in_valid = 4'b1000; in_data = 32'hC3000000;
        for (int k = 0; k < 17; k++) step();
        n_checks++; if (beat_cnt_a !== 16'h1000 || out_valid_a !== 1'b1 || out_chan_a !== 2'd3) begin
            n_fail++; $display("FAIL wrap: got cnt=%h v=%b chan=%0d expected 1000/1/3", beat_cnt_a, out_valid_a, out_chan_a);
        end
        reset = 1'b0;
        step();
        n_checks++; if (out_valid_a !== 1'b0 || out_data_a !== 8'h00 || out_chan_a !== 2'd0 || beat_cnt_a !== 16'h0 || in_ready_a !== 4'h0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b data=%h chan=%0d cnt=%h ready=%b expected 0/00/0/0000/0000", out_valid_a, out_data_a, out_chan_a, beat_cnt_a, in_ready_a);
        end
        reset = 1'b1; in_valid = 4'hF;
        #1;
        n_checks++; if (in_ready_a !== 4'b0001) begin n_fail++; $display("FAIL post_reset_ptr: got %b expected 0001", in_ready_a); end
        in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_random();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
